dmem_ctrl: RTL and testbench

Data-memory controller that sits directly downstream of the core's execute stage. It consumes the core's `mem_in_s` request bundle and 32-bit byte address, performs word or byte loads/stores against a local SRAM array with a fixed programmable latency, and returns a `mem_out_s` response using the same valid/yumi handshake the core drives. It holds exactly one request in flight.

---
 rtl/dmem_ctrl_pkg.sv | 32 +++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_ctrl.sv | 130 +++++++++++++
 tb/tb_dmem_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: core request/response
// bundles, controller FSM states and latency-counter width.
package dmem_ctrl_pkg;

  localparam int dmem_lat_width_gp = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  // One-hot byte enable for a little-endian lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous SRAM, 2^addr_width_p x 32, byte-enable write and
// registered read. Contents are never reset.
module dmem_array #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [addr_width_p-1:0] addr,
  input  logic [3:0]              be,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  logic [3:0][7:0] mem [2**addr_width_p];
  logic [31:0]     rdata_reg;

  // Read register only updates on a read access, so data holds afterwards.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][i] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request in flight, fixed latency_p response.
// Byte loads/stores are built only when DMEM_BYTE_OP_EN is defined.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  mem_in_s     to_mem_i,
  input  logic [31:0] addr_i,
  output mem_out_s    from_mem_o
);

  localparam logic [dmem_lat_width_gp-1:0] lat_load_lp = dmem_lat_width_gp'(latency_p - 1);

  dmem_state_e                  state_reg, state_next;
  logic [dmem_lat_width_gp-1:0] cnt_reg, cnt_next;
  logic                         wen_reg;
  logic [31:0]                  resp_reg;
  logic                         accept;
  logic                         load_resp;
  logic [3:0]                   arr_be;
  logic [31:0]                  arr_wdata;
  logic [31:0]                  arr_rdata;
  logic [31:0]                  load_data;
  logic [31:0]                  read_data;

  // Acceptance is gated by reset so yumi stays low while reset is held.
  assign accept    = reset && (state_reg == IDLE) && to_mem_i.valid;
  assign load_resp = (state_reg == BUSY) && (cnt_reg == '0);

`ifdef DMEM_BYTE_OP_EN
  logic       bnw_reg;
  logic [1:0] lane_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bnw_reg  <= 1'b0;
      lane_reg <= 2'd0;
    end else if (accept) begin
      bnw_reg  <= to_mem_i.byte_not_word;
      lane_reg <= addr_i[1:0];
    end
  end

  assign arr_be    = to_mem_i.byte_not_word ? lane_mask(addr_i[1:0]) : 4'hF;
  assign arr_wdata = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}} : to_mem_i.write_data;
  assign load_data = bnw_reg ? {24'd0, arr_rdata[{lane_reg, 3'b000} +: 8]} : arr_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:addr_width_p+2];
`else
  assign arr_be    = 4'hF;
  assign arr_wdata = to_mem_i.write_data;
  assign load_data = arr_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:addr_width_p+2], addr_i[1:0], to_mem_i.byte_not_word};
`endif

  dmem_array #(
    .addr_width_p(addr_width_p)
  ) u_array (
    .clk  (clk),
    .en   (accept),
    .we   (to_mem_i.wen),
    .addr (addr_i[addr_width_p+1:2]),
    .be   (arr_be),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wen_reg   <= 1'b0;
      resp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) wen_reg <= to_mem_i.wen;
      if (load_resp) begin
        resp_reg <= wen_reg ? 32'd0 : load_data;
      end else if ((state_reg == RESP) && to_mem_i.yumi) begin
        resp_reg <= '0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = lat_load_lp;
          state_next = (latency_p == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == '0) state_next = RESP;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      RESP: begin
        if (to_mem_i.yumi) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With a single-cycle latency the array output is already held stable in RESP.
  generate
    if (latency_p == 1) begin : g_lat1
      assign read_data = ((state_reg == RESP) && !wen_reg) ? load_data : 32'd0;
    end else begin : g_latn
      assign read_data = resp_reg;
    end
  endgenerate

  always_comb begin
    from_mem_o           = '0;
    from_mem_o.read_data = read_data;
    from_mem_o.valid     = (state_reg == RESP);
    from_mem_o.yumi      = accept;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (default parameters); byte-lane
// expectations follow DMEM_BYTE_OP_EN.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  mem_in_s     to_mem;
  logic [31:0] addr;
  mem_out_s    from_mem;

  int checks = 0;
  int errors = 0;

`ifdef DMEM_BYTE_OP_EN
  localparam logic [31:0] exp_word10 = 32'hA5ADBEEF;
  localparam logic [31:0] exp_byte12 = 32'h000000AD;
`else
  localparam logic [31:0] exp_word10 = 32'h000000A5;
  localparam logic [31:0] exp_byte12 = 32'h000000A5;
`endif

  dmem_ctrl #(
    .addr_width_p(10),
    .latency_p   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .to_mem_i  (to_mem),
    .addr_i    (addr),
    .from_mem_o(from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full handshake; starts and ends 1 time unit after a rising edge.
  task automatic do_req(input logic wen, input logic bnw, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output int lat, output logic acc);
    to_mem.valid         = 1'b1;
    to_mem.wen           = wen;
    to_mem.byte_not_word = bnw;
    to_mem.write_data    = wd;
    addr                 = a;
    #1;
    acc = from_mem.yumi;
    @(posedge clk); #1;
    to_mem.valid = 1'b0;
    lat = 0;
    while (from_mem.valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = from_mem.read_data;
    to_mem.yumi = 1'b1;
    @(posedge clk); #1;
    to_mem.yumi = 1'b0;
    $display("txn wen=%0d byte=%0d addr=%h wdata=%h rdata=%h lat=%0d", wen, bnw, a, wd, rdata, lat);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    to_mem = '0;
    addr   = '0;
    #1 reset = 1'b0;
    to_mem.valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (from_mem.yumi !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b exp 0", from_mem.yumi); end
    checks++; if (from_mem.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", from_mem.valid); end
    checks++; if (from_mem.read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", from_mem.read_data); end
    reset = 1'b1;
    #1;
    checks++; if (from_mem.yumi !== 1'b1) begin errors++; $display("FAIL release_yumi got %b exp 1", from_mem.yumi); end
    to_mem.valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (from_mem.valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", from_mem.valid); end
  endtask

  task automatic test_word();
    logic [31:0] rd; int lat; logic acc;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, lat, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL wstore_accept got %b exp 1", acc); end
    checks++; if (lat != 2) begin errors++; $display("FAIL wstore_lat got %0d exp 2", lat); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wstore_rdata got %h exp 0", rd); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL wload_accept got %b exp 1", acc); end
    checks++; if (lat != 2) begin errors++; $display("FAIL wload_lat got %0d exp 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wload_rdata got %h exp DEADBEEF", rd); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; int lat; logic acc;
    do_req(1'b1, 1'b1, 32'h13, 32'h000000A5, rd, lat, acc);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL bstore_rdata got %h exp 0", rd); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, acc);
    checks++; if (rd !== exp_word10) begin errors++; $display("FAIL bmerge_rdata got %h exp %h", rd, exp_word10); end
    do_req(1'b0, 1'b1, 32'h12, 32'h0, rd, lat, acc);
    checks++; if (rd !== exp_byte12) begin errors++; $display("FAIL bload_rdata got %h exp %h", rd, exp_byte12); end
    checks++; if (lat != 2) begin errors++; $display("FAIL bload_lat got %0d exp 2", lat); end
  endtask

  task automatic test_withhold();
    logic [31:0] rd; int lat; logic acc;
    to_mem.valid = 1'b1; to_mem.wen = 1'b0; to_mem.byte_not_word = 1'b0; addr = 32'h10;
    #1;
    checks++; if (from_mem.yumi !== 1'b1) begin errors++; $display("FAIL hold_first_yumi got %b exp 1", from_mem.yumi); end
    @(posedge clk); #1;
    // second request stays pending for the whole first transaction
    to_mem.wen = 1'b1; to_mem.write_data = 32'h11223344; addr = 32'h20;
    #1;
    checks++; if (from_mem.yumi !== 1'b0) begin errors++; $display("FAIL hold_busy_yumi got %b exp 0", from_mem.yumi); end
    lat = 0;
    while (from_mem.valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 2) begin errors++; $display("FAIL hold_lat got %0d exp 2", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (from_mem.valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, from_mem.valid); end
      checks++; if (from_mem.yumi !== 1'b0) begin errors++; $display("FAIL hold_yumi[%0d] got %b exp 0", i, from_mem.yumi); end
      checks++; if (from_mem.read_data !== exp_word10) begin errors++; $display("FAIL hold_rdata[%0d] got %h exp %h", i, from_mem.read_data, exp_word10); end
    end
    to_mem.yumi = 1'b1;
    #1;
    checks++; if (from_mem.yumi !== 1'b0) begin errors++; $display("FAIL hold_release_yumi got %b exp 0", from_mem.yumi); end
    @(posedge clk); #1;
    to_mem.yumi = 1'b0;
    #1;
    checks++; if (from_mem.valid !== 1'b0) begin errors++; $display("FAIL hold_idle_valid got %b exp 0", from_mem.valid); end
    checks++; if (from_mem.yumi !== 1'b1) begin errors++; $display("FAIL hold_second_yumi got %b exp 1", from_mem.yumi); end
    @(posedge clk); #1;
    to_mem.valid = 1'b0;
    lat = 0;
    while (from_mem.valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 2) begin errors++; $display("FAIL second_lat got %0d exp 2", lat); end
    checks++; if (from_mem.read_data !== 32'd0) begin errors++; $display("FAIL second_rdata got %h exp 0", from_mem.read_data); end
    to_mem.yumi = 1'b1;
    @(posedge clk); #1;
    to_mem.yumi = 1'b0;
    $display("txn wen=1 byte=0 addr=00000020 wdata=11223344 (pending behind load)");
    do_req(1'b0, 1'b0, 32'h20, 32'h0, rd, lat, acc);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL second_readback got %h exp 11223344", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic acc;
    to_mem.valid = 1'b1; to_mem.wen = 1'b0; to_mem.byte_not_word = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    to_mem.valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (from_mem.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", from_mem.valid); end
    #3 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (from_mem.valid !== 1'b0) begin errors++; $display("FAIL midrst_after_valid[%0d] got %b exp 0", i, from_mem.valid); end
    end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL midrst_next_accept got %b exp 1", acc); end
    checks++; if (lat != 2) begin errors++; $display("FAIL midrst_next_lat got %0d exp 2", lat); end
    checks++; if (rd !== exp_word10) begin errors++; $display("FAIL midrst_next_rdata got %h exp %h", rd, exp_word10); end
  endtask

  task automatic test_alias();
    logic [31:0] rd; int lat; logic acc;
    do_req(1'b1, 1'b0, 32'h1010, 32'hCAFEF00D, rd, lat, acc);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat, acc);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL alias_rdata got %h exp CAFEF00D", rd); end
    do_req(1'b0, 1'b0, 32'h13, 32'h0, rd, lat, acc);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL word_lane_ignored got %h exp CAFEF00D", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_withhold();
    test_reset_mid();
    test_alias();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
